// File: rtl/a2_serdes_pkg.sv
// Shared serial-link definitions for the serializer and deserializer sides.
package a2_serdes_pkg;

  // Shortest legal burst; anything shorter is discarded by the receiver.
  localparam int unsigned MIN_BITS = 3;

  typedef enum logic {
    IDLE,
    RECV
  } state_e;

  // Counter width able to hold the value `width` itself.
  function automatic int unsigned mod_bits(int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/a2_deserializer_if.sv
// Serial input, consumer handshake and status signals of the deserializer.
interface a2_deserializer_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_BITS = a2_serdes_pkg::mod_bits(WIDTH)
);
  logic                ser_data_i;
  logic                ser_data_val_i;
  logic                ready_i;
  logic [WIDTH-1:0]    data_o;
  logic [MOD_BITS-1:0] data_mod_o;
  logic                data_val_o;
  logic                busy_o;
  logic                len_err_o;
  logic                overrun_o;

  // Link/consumer side: drives serial bits and ready, observes the word.
  modport master (
    output ser_data_i, ser_data_val_i, ready_i,
    input  data_o, data_mod_o, data_val_o, busy_o, len_err_o, overrun_o
  );

  // Deserializer side.
  modport slave (
    input  ser_data_i, ser_data_val_i, ready_i,
    output data_o, data_mod_o, data_val_o, busy_o, len_err_o, overrun_o
  );
endinterface

// File: rtl/a2_deser_hold.sv
// One-word valid/ready hold register with overrun detection.
module a2_deser_hold #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    word_i,
  input  logic [MOD_BITS-1:0] mod_i,
  input  logic                ready_i,
  output logic [WIDTH-1:0]    data_o,
  output logic [MOD_BITS-1:0] data_mod_o,
  output logic                data_val_o,
  output logic                overrun_o
);
  logic [WIDTH-1:0]    data_q, data_d;
  logic [MOD_BITS-1:0] mod_q, mod_d;
  logic                val_q, val_d;
  logic                overrun_q, overrun_d;
  logic                take;

  // Load when empty or when the held word is accepted in the same cycle.
  always_comb begin
    take      = load_i & (~val_q | ready_i);
    data_d    = data_q;
    mod_d     = mod_q;
    val_d     = val_q;
    overrun_d = load_i & val_q & ~ready_i;
    if (take) begin
      data_d = word_i;
      mod_d  = mod_i;
      val_d  = 1'b1;
    end else if (val_q && ready_i) begin
      val_d = 1'b0;
    end
  end

  // Hold register state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q    <= '0;
      mod_q     <= '0;
      val_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      mod_q     <= mod_d;
      val_q     <= val_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign data_val_o = val_q;
  assign overrun_o  = overrun_q;
endmodule

// File: rtl/a2_deserializer.sv
// Rebuilds MSB-first serial bursts into MSB-aligned words with a bit count.
module a2_deserializer
  import a2_serdes_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_BITS = mod_bits(WIDTH),
  parameter int unsigned MIN_BITS = a2_serdes_pkg::MIN_BITS
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  a2_deserializer_if.slave bus
);
  state_e              state_q, state_d;
  logic [MOD_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                len_err_q, len_err_d;
  logic                done;
  logic                legal;
  logic [MOD_BITS-1:0] len;
  logic [WIDTH-1:0]    word;
  logic [WIDTH-1:0]    ser_word;

  // Next state, bit capture and completion detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    done     = 1'b0;
    len      = cnt_q;
    word     = acc_q;
    // Incoming bit positioned at acc[WIDTH-1-cnt]; only meaningful in RECV.
    ser_word = {{(WIDTH-1){1'b0}}, bus.ser_data_i} << (MOD_BITS'(WIDTH - 1) - cnt_q);
    unique case (state_q)
      IDLE: begin
        if (bus.ser_data_val_i) begin
          acc_d            = '0;
          acc_d[WIDTH-1]   = bus.ser_data_i;
          cnt_d            = MOD_BITS'(1);
          state_d          = RECV;
        end
      end
      RECV: begin
        if (bus.ser_data_val_i) begin
          acc_d = acc_q | ser_word;
          if (cnt_q == MOD_BITS'(WIDTH - 1)) begin
            // Final bit of a full-width burst: complete without waiting for val to drop.
            done    = 1'b1;
            len     = MOD_BITS'(WIDTH);
            word    = acc_d;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + MOD_BITS'(1);
          end
        end else begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    legal     = (len >= MOD_BITS'(MIN_BITS));
    len_err_d = done & ~legal;
  end

  // FSM, counter, accumulator and length-error pulse registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      len_err_q <= len_err_d;
    end
  end

  a2_deser_hold #(
    .WIDTH    (WIDTH),
    .MOD_BITS (MOD_BITS)
  ) u_hold (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (done & legal),
    .word_i     (word),
    .mod_i      (len),
    .ready_i    (bus.ready_i),
    .data_o     (bus.data_o),
    .data_mod_o (bus.data_mod_o),
    .data_val_o (bus.data_val_o),
    .overrun_o  (bus.overrun_o)
  );

  assign bus.busy_o    = (cnt_q != '0);
  assign bus.len_err_o = len_err_q;
endmodule
